// File: rtl/ws2812_write_queue_if.sv
// Wishbone slave bus of the ws2812 write queue, grouped so the top and the
// bench share one definition of the handshake signals.
interface ws2812_write_queue_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/ws2812_write_queue.sv
// Wishbone write buffer in front of the ws2812 driver. Firmware pushes
// {led_num, rgb} words into a FIFO; a small FSM replays them as one-cycle
// write strobes separated by DRAIN_GAP idle cycles.
module ws2812_write_queue #(
    parameter logic [31:0] BASE_ADDR = 32'h30000100,
    parameter int          DEPTH     = 8,
    parameter int          DRAIN_GAP = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ws2812_write_queue_if.slave  wb,
    output logic [7:0]           led_num,
    output logic [23:0]          rgb_data,
    output logic                 write
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [15:0] GAP_LAST = 16'(DRAIN_GAP - 1);

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    state_t        state;
    logic [15:0]   gap_cnt;

    logic hit_data, hit_status, hit_ctrl, req;
    logic full, empty, push_req, push, pop, flush, clr_ovf;
    logic [31:0] status;

    assign hit_data   = wb.wbs_adr_i == BASE_ADDR;
    assign hit_status = wb.wbs_adr_i == BASE_ADDR + 32'd4;
    assign hit_ctrl   = wb.wbs_adr_i == BASE_ADDR + 32'd8;

    // A request acts only on the edge that raises ack, so a strobe held
    // through the ack cycle has no second effect.
    assign req = wb.wbs_cyc_i & wb.wbs_stb_i & (hit_data | hit_status | hit_ctrl) & ~wb.wbs_ack_o;

    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    assign push_req = req & wb.wbs_we_i & hit_data & (wb.wbs_sel_i == 4'hF);
    // Fullness is judged before the edge; a same-edge pop does not make room.
    assign push     = push_req & ~full;
    assign flush    = req & wb.wbs_we_i & hit_ctrl & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
    assign clr_ovf  = req & wb.wbs_we_i & hit_ctrl & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];
    assign pop      = (state == IDLE) & ~empty;
    assign status   = {16'b0, 8'(count), 5'b0, overflow, full, empty};

    // Wishbone response: single-cycle ack, read data only while acked.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
        end else begin
            wb.wbs_ack_o <= req;
            wb.wbs_dat_o <= (req && !wb.wbs_we_i && hit_status) ? status : '0;
        end
    end

    // FIFO storage; contents need no reset since count guards every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wb.wbs_dat_i;
    end

    // Pointers and occupancy; flush wins over any same-edge push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
        end
    end

    // Sticky overflow: set by a dropped push, cleared only through CTRL.
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (clr_ovf)
            overflow <= 1'b0;
        else if (push_req && full)
            overflow <= 1'b1;
    end

    // Drain FSM: pop in IDLE, strobe write from WRITE, then sit out the gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            write    <= 1'b0;
            led_num  <= '0;
            rgb_data <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    write <= 1'b0;
                    if (pop) begin
                        led_num  <= mem[rd_ptr][31:24];
                        rgb_data <= mem[rd_ptr][23:0];
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    write   <= 1'b1;
                    gap_cnt <= '0;
                    state   <= (DRAIN_GAP > 0) ? GAP : IDLE;
                end
                GAP: begin
                    write <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    write <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_write_queue.sv
// Bench for ws2812_write_queue: three instances (gap 16, 1000, 0) share one
// wishbone stimulus; each has a queue-based reference model checked every cycle.
module tb_ws2812_write_queue;
    localparam logic [31:0] BASE  = 32'h30000100;
    localparam int          DEPTH = 8;

    logic        clk, reset;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;

    int n_chk = 0, n_fail = 0, cycle = 0;
    int pc [3];
    int pt0 [$];

    function automatic logic mapped(input logic [31:0] a);
        return (a == BASE) || (a == BASE + 32'd4) || (a == BASE + 32'd8);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int G = (g == 0) ? 16 : (g == 1) ? 1000 : 0;

        ws2812_write_queue_if wb();
        logic [7:0]  led_num;
        logic [23:0] rgb_data;
        logic        write;

        assign wb.wbs_cyc_i = cyc;
        assign wb.wbs_stb_i = stb;
        assign wb.wbs_we_i  = we;
        assign wb.wbs_sel_i = sel;
        assign wb.wbs_adr_i = adr;
        assign wb.wbs_dat_i = dat;

        ws2812_write_queue #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DRAIN_GAP(G)) dut (
            .clk(clk), .reset(reset), .wb(wb),
            .led_num(led_num), .rgb_data(rgb_data), .write(write)
        );

        // Reference: a queue of words, a busy timer for the drain, and the
        // expected registered bus outputs.
        logic [31:0] q [$];
        logic        m_ack = 0, m_write = 0, m_ovf = 0;
        logic [31:0] m_dat = 0, m_head = 0;
        int          m_t = 0;

        always @(posedge clk) begin : model
            int          sz;
            logic        nack, nwr, dopop;
            logic [31:0] nd;
            if (reset) begin
                q.delete();
                m_ack = 0; m_dat = 0; m_write = 0; m_ovf = 0; m_head = 0; m_t = 0;
            end else begin
                sz    = q.size();
                nack  = cyc && stb && mapped(adr) && !m_ack;
                nd    = 0;
                if (nack && !we && adr == BASE + 32'd4)
                    nd = {16'b0, 8'(sz), 5'b0, m_ovf, (sz == DEPTH), (sz == 0)};
                nwr   = (m_t == G + 1);
                dopop = (m_t == 0) && (sz > 0);
                if (m_t > 0) m_t--;
                if (dopop) begin
                    m_head = q.pop_front();
                    m_t    = G + 1;
                end
                if (nack && we && adr == BASE && sel == 4'hF) begin
                    if (sz == DEPTH) m_ovf = 1;
                    else q.push_back(dat);
                end
                if (nack && we && adr == BASE + 32'd8 && sel[0]) begin
                    if (dat[0]) q.delete();
                    if (dat[1]) m_ovf = 0;
                end
                m_ack = nack; m_dat = nd; m_write = nwr;
            end
        end
    end

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_one(input int i, input logic a, input logic [31:0] d, input logic w,
                             input logic [7:0] l, input logic [23:0] r, input logic ma,
                             input logic [31:0] md, input logic mw, input logic [31:0] mh);
        chk($sformatf("ack[%0d]", i), {31'b0, a}, {31'b0, ma});
        chk($sformatf("dat_o[%0d]", i), d, md);
        chk($sformatf("write[%0d]", i), {31'b0, w}, {31'b0, mw});
        if (mw) begin
            chk($sformatf("led_num[%0d]", i), {24'b0, l}, {24'b0, mh[31:24]});
            chk($sformatf("rgb_data[%0d]", i), {8'b0, r}, {8'b0, mh[23:0]});
        end
        if (w === 1'b1) begin
            pc[i]++;
            if (i == 0) pt0.push_back(cycle);
        end
    endtask

    task automatic check_all();
        check_one(0, u[0].wb.wbs_ack_o, u[0].wb.wbs_dat_o, u[0].write, u[0].led_num, u[0].rgb_data,
                  u[0].m_ack, u[0].m_dat, u[0].m_write, u[0].m_head);
        check_one(1, u[1].wb.wbs_ack_o, u[1].wb.wbs_dat_o, u[1].write, u[1].led_num, u[1].rgb_data,
                  u[1].m_ack, u[1].m_dat, u[1].m_write, u[1].m_head);
        check_one(2, u[2].wb.wbs_ack_o, u[2].wb.wbs_dat_o, u[2].write, u[2].led_num, u[2].rgb_data,
                  u[2].m_ack, u[2].m_dat, u[2].m_write, u[2].m_head);
    endtask

    // Compare on the falling edge, then move to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1;
        idle(2);
        reset = 0;
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                       input logic st, input logic exp_ack, output logic [2:0][31:0] rd);
        logic got;
        got = 0;
        rd  = '0;
        cyc = 1; stb = st; we = w; sel = s; adr = a; dat = d;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (u[0].wb.wbs_ack_o === 1'b1) begin
                got = 1;
                rd  = {u[2].wb.wbs_dat_o, u[1].wb.wbs_dat_o, u[0].wb.wbs_dat_o};
            end
        end
        cyc = 0; stb = 0; we = 0; sel = 0;
        chk("bus_ack", {31'b0, got}, {31'b0, exp_ack});
    endtask

    task automatic wr_data(input logic [31:0] d);
        logic [2:0][31:0] rd;
        bus(BASE, 1, 4'hF, d, 1, 1, rd);
    endtask

    task automatic wr_ctrl(input logic [31:0] d);
        logic [2:0][31:0] rd;
        bus(BASE + 32'd8, 1, 4'hF, d, 1, 1, rd);
    endtask

    task automatic rd_status(output logic [2:0][31:0] rd);
        bus(BASE + 32'd4, 0, 4'hF, 0, 1, 1, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [2:0][31:0] rd;
        int base, k;
        logic [31:0] a, d;
        logic w, st;
        logic [3:0] s;

        reset = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
        foreach (pc[i]) pc[i] = 0;
        @(posedge clk); #1;
        idle(2);
        reset = 0;

        // Reset state and an empty STATUS read; nothing drains while empty.
        chk("led_rst0", {24'b0, u[0].led_num}, 0);
        chk("rgb_rst0", {8'b0, u[0].rgb_data}, 0);
        chk("led_rst1", {24'b0, u[1].led_num}, 0);
        chk("rgb_rst1", {8'b0, u[1].rgb_data}, 0);
        rd_status(rd);
        chk("st_reset", rd[0], 32'h00000001);
        base = pc[0] + pc[1] + pc[2];
        idle(100);
        chk("no_write_idle", pc[0] + pc[1] + pc[2] - base, 0);

        // Single push: write strobe two cycles after ack.
        wr_data(32'h05FF8000);
        tick();
        chk("wr_lat_n1", {31'b0, u[0].write}, 0);
        tick();
        chk("wr_lat_n2", {31'b0, u[0].write}, 1);
        chk("wr_led", {24'b0, u[0].led_num}, 32'h05);
        chk("wr_rgb", {8'b0, u[0].rgb_data}, 32'hFF8000);
        idle(30);

        // Eight back-to-back pushes drain in order, 18 cycles apart.
        base = pt0.size();
        for (int i = 0; i < 8; i++) wr_data($urandom);
        rd_status(rd);
        chk("st_cnt78", {31'b0, (rd[0][15:8] == 8'd7) || (rd[0][15:8] == 8'd8)}, 1);
        idle(8 * 18 + 20);
        rd_status(rd);
        chk("st_drained", {31'b0, rd[0][0]}, 1);
        chk("pulse_cnt", pt0.size() - base, 8);
        for (int i = 0; i < 7 && base + i + 1 < pt0.size(); i++)
            chk($sformatf("spacing%0d", i), pt0[base + i + 1] - pt0[base + i], 18);

        // Overflow on the long-gap instance, then clear it.
        do_reset();
        for (int i = 0; i < 10; i++) wr_data(32'h10000000 | i);
        rd_status(rd);
        chk("st_ovf", rd[1], 32'h00000806);
        wr_ctrl(32'h2);
        rd_status(rd);
        chk("st_ovf_clr", rd[1], 32'h00000802);

        // Flush while the gap is running: no pulses beyond the one in flight.
        do_reset();
        base = pc[1];
        for (int i = 0; i < 5; i++) wr_data(32'h20000000 | i);
        wr_ctrl(32'h1);
        rd_status(rd);
        chk("st_flush", rd[1], 32'h00000001);
        idle(1100);
        chk("flush_pulses", pc[1] - base, 1);

        // Partial select, unmapped address, reset mid-gap with a request pending.
        do_reset();
        bus(BASE, 1, 4'h1, 32'hAABBCCDD, 1, 1, rd);
        rd_status(rd);
        chk("st_partial", rd[1], 32'h00000001);
        bus(BASE + 32'd12, 1, 4'hF, 32'h1, 1, 0, rd);
        wr_data(32'h07123456);
        idle(20);
        reset = 1; cyc = 1; stb = 1; we = 1; sel = 4'hF; adr = BASE; dat = 32'h01010101;
        tick();
        chk("rst_write", {31'b0, u[1].write}, 0);
        chk("rst_led", {24'b0, u[1].led_num}, 0);
        chk("rst_rgb", {8'b0, u[1].rgb_data}, 0);
        chk("rst_ack", {31'b0, u[1].wb.wbs_ack_o}, 0);
        reset = 0; cyc = 0; stb = 0; we = 0; sel = 0;
        rd_status(rd);
        chk("st_after_rst", rd[1], 32'h00000001);

        // Random traffic against the models.
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 4)      a = BASE;
            else if (k <= 6) a = BASE + 32'd4;
            else if (k == 7) a = BASE + 32'd8;
            else if (k == 8) a = BASE + 32'd12;
            else             a = $urandom;
            w  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            d  = $urandom;
            if (a == BASE + 32'd8)
                d = {30'b0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1)};
            st = ($urandom_range(0, 15) != 0);
            bus(a, w, s, d, st, st && mapped(a), rd);
            idle($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
